sdr_rom_port_arbiter: RTL and testbench

Responder side of the single-cycle `sdr_req`/`sdr_addr` → `sdr_rdy`/`sdr_data` ROM fetch protocol used by the tile and sprite layers (BACK1, BACK2, FRONT, OBJ). The block latches one-cycle request strobes from up to `PORTS` layer fetchers and arbitrates them round-robin onto a single SDRAM read channel. Only one read is outstanding at a time. Each word is returned to its originating port as a registered data word plus a one-cycle ready pulse. Requests superseded before completion are silently discarded.

---
 rtl/sdr_rom_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sdr_rom_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_rom_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module : sdr_rom_port_arbiter                                          |
// | Brief  : Round-robin arbiter of layer ROM fetch ports onto one SDRAM   |
// |          read channel, one read outstanding, stale replies dropped.    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module sdr_rom_port_arbiter #(
  parameter int PORTS = 4,
  parameter int AW    = 25,
  parameter int DW    = 16
) (
  input  logic                clk_ram,
  input  logic                reset,
  input  logic [PORTS-1:0]    req,
  input  logic [PORTS*AW-1:0] req_addr,
  output logic [PORTS-1:0]    rdy,
  output logic [PORTS*DW-1:0] rdata,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  input  logic                mem_ack,
  input  logic                mem_dvalid,
  input  logic [DW-1:0]       mem_dout
);

  localparam int                  c_SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [c_SEL_W-1:0]  c_LAST  = c_SEL_W'(PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_SEL_W-1:0]   r_sel, r_rr_ptr, w_sel;
  logic [PORTS-1:0]     r_pend, r_stale, r_rdy;
  logic [PORTS-1:0]     w_sel_oh, r_sel_oh;
  logic [AW-1:0]        r_paddr [PORTS];
  logic [DW-1:0]        r_rdata [PORTS];
  logic [AW-1:0]        r_mem_addr;
  logic                 r_mem_rd;
  logic                 w_any, w_issue, w_ackd, w_done, w_deliver;

  // Walk from the highest offset down so the first pending port at/after rr_ptr wins.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = 0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = (int'(r_rr_ptr) + i) % PORTS;
      if (r_pend[idx]) begin
        w_any = 1'b1;
        w_sel = idx[c_SEL_W-1:0];
      end
    end
  end

  assign w_sel_oh = PORTS'(1) << w_sel;
  assign r_sel_oh = PORTS'(1) << r_sel;

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Ack and data in the same ISSUE cycle is handled as ack followed by data.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ackd      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          w_ackd = 1'b1;
          if (mem_dvalid) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_dvalid) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_deliver = w_done && !r_stale[r_sel];

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_pend     <= '0;
      r_stale    <= '0;
      r_rdy      <= '0;
      for (int p = 0; p < PORTS; p++) begin
        r_paddr[p] <= '0;
        r_rdata[p] <= '1;
      end
    end else begin
      if (w_issue) begin
        r_sel      <= w_sel;
        r_rr_ptr   <= (w_sel == c_LAST) ? '0 : w_sel + 1'b1;
        r_mem_addr <= r_paddr[w_sel];
        r_mem_rd   <= 1'b1;
      end else if (w_ackd) begin
        r_mem_rd   <= 1'b0;
      end
      for (int p = 0; p < PORTS; p++) begin
        // A fresh strobe always beats the issue that would clear this port.
        if (req[p]) begin
          r_pend[p]  <= 1'b1;
          r_paddr[p] <= req_addr[p*AW +: AW];
        end else if (w_issue && w_sel_oh[p]) begin
          r_pend[p]  <= 1'b0;
        end
        if (req[p] && ((r_state != ST_IDLE && r_sel_oh[p]) || (w_issue && w_sel_oh[p])))
          r_stale[p] <= 1'b1;
        else if (w_issue && w_sel_oh[p])
          r_stale[p] <= 1'b0;
        r_rdy[p] <= w_deliver && r_sel_oh[p];
        if (w_deliver && r_sel_oh[p])
          r_rdata[p] <= mem_dout;
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_out
    assign rdata[p*DW +: DW] = r_rdata[p];
  end

  assign rdy      = r_rdy;
  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;

endmodule
`default_nettype wire

// File: tb/tb_sdr_rom_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module : tb_sdr_rom_port_arbiter                                       |
// | Brief  : Directed self-checking bench for sdr_rom_port_arbiter.        |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_sdr_rom_port_arbiter;
  localparam int PORTS = 4;
  localparam int AW    = 25;
  localparam int DW    = 16;

  logic                clk_ram = 1'b0;
  logic                reset   = 1'b1;
  logic [PORTS-1:0]    req     = '0;
  logic [PORTS*AW-1:0] req_addr = '0;
  logic [PORTS-1:0]    rdy;
  logic [PORTS*DW-1:0] rdata;
  logic [AW-1:0]       mem_addr;
  logic                mem_rd;
  logic                mem_ack    = 1'b0;
  logic                mem_dvalid = 1'b0;
  logic [DW-1:0]       mem_dout   = '0;

  sdr_rom_port_arbiter #(.PORTS(PORTS), .AW(AW), .DW(DW)) dut (
    .clk_ram    (clk_ram),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .rdy        (rdy),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_ack    (mem_ack),
    .mem_dvalid (mem_dvalid),
    .mem_dout   (mem_dout)
  );

  always #5 clk_ram = ~clk_ram;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] issue_q [$];
  int            rdy_port_q [$];
  logic [DW-1:0] rdy_data_q [$];
  int            multi_rdy = 0;
  logic          prev_rd   = 1'b0;

  // Event recorder, sampled 2ns after each rising edge.
  always begin
    @(posedge clk_ram);
    #2;
    if (reset) begin
      prev_rd = 1'b0;
    end else begin
      if (mem_rd && !prev_rd) issue_q.push_back(mem_addr);
      prev_rd = mem_rd;
      if ($countones(rdy) > 1) multi_rdy++;
      for (int p = 0; p < PORTS; p++)
        if (rdy[p]) begin
          rdy_port_q.push_back(p);
          rdy_data_q.push_back(rdata[p*DW +: DW]);
        end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_ram);
  endtask

  task automatic clear_q();
    issue_q.delete();
    rdy_port_q.delete();
    rdy_data_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    clear_q();
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a);
    req[p] = 1'b1;
    req_addr[p*AW +: AW] = a;
  endtask

  task automatic fire();
    tick(1);
    req = '0;
  endtask

  task automatic wait_rd(output bit ok);
    int n = 0;
    while (mem_rd !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    ok = (mem_rd === 1'b1);
  endtask

  // Controller model: ack after ack_dly cycles, data dv_dly cycles after ack.
  task automatic serve(input int ack_dly, input int dv_dly, input logic [DW-1:0] d, output bit ok);
    wait_rd(ok);
    if (!ok) return;
    tick(ack_dly);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    tick(dv_dly);
    mem_dout   = d;
    mem_dvalid = 1'b1;
    tick(1);
    mem_dvalid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else n_pass++;
    n_checks++; if (rdy !== '0) $display("FAIL reset_rdy: got %b expected 0", rdy); else n_pass++;
    n_checks++; if (rdata !== {PORTS*DW{1'b1}}) $display("FAIL reset_rdata: got %h expected all ones", rdata); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    set_req(1, 25'h0A0020);
    fire();
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL single_latency_early: got mem_rd=%b expected 0", mem_rd); else n_pass++;
    tick(1);
    n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 25'h0A0020) $display("FAIL single_issue: got rd=%b addr=%h expected rd=1 addr=0a0020", mem_rd, mem_addr); else n_pass++;
    serve(2, 4, 16'hBEEF, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: mem_rd never rose"); else n_pass++;
    n_checks++; if (rdy !== 4'b0010) $display("FAIL single_rdy_pulse: got %b expected 0010", rdy); else n_pass++;
    tick(1);
    n_checks++; if (rdy !== 4'b0000) $display("FAIL single_rdy_width: got %b expected 0000", rdy); else n_pass++;
    n_checks++; if (rdata[DW +: DW] !== 16'hBEEF) $display("FAIL single_rdata1: got %h expected beef", rdata[DW +: DW]); else n_pass++;
    n_checks++; if ({rdata[63:32], rdata[15:0]} !== 48'hFFFF_FFFF_FFFF) $display("FAIL single_others: got %h expected ffffffffffff", {rdata[63:32], rdata[15:0]}); else n_pass++;
    n_checks++; if (issue_q.size() != 1 || mem_rd !== 1'b0) $display("FAIL single_issue_count: got %0d reads rd=%b expected 1 read rd=0", issue_q.size(), mem_rd); else n_pass++;
  endtask

  task automatic test_burst();
    bit ok, all_ok;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      clear_q();
      all_ok = 1'b1;
      for (int p = 0; p < PORTS; p++) set_req(p, 25'h001000 * (b + 1) + 25'(p));
      fire();
      for (int k = 0; k < PORTS; k++) begin
        serve(1, 2, 16'hA000 + 16'(b * 16'h1000) + 16'(k), ok);
        all_ok &= ok;
      end
      tick(1);
      n_checks++; if (!all_ok || issue_q.size() != 4 || rdy_port_q.size() != 4) $display("FAIL burst%0d_counts: got ok=%b reads=%0d rdys=%0d expected 1/4/4", b, all_ok, issue_q.size(), rdy_port_q.size()); else n_pass++;
      for (int k = 0; k < PORTS && k < issue_q.size() && k < rdy_port_q.size(); k++) begin
        n_checks++;
        if (issue_q[k] !== 25'h001000 * (b + 1) + 25'(k) || rdy_port_q[k] != k || rdy_data_q[k] !== 16'hA000 + 16'(b * 16'h1000) + 16'(k))
          $display("FAIL burst%0d_slot%0d: got addr=%h port=%0d data=%h expected addr=%h port=%0d data=%h", b, k, issue_q[k], rdy_port_q[k], rdy_data_q[k], 25'h001000 * (b + 1) + 25'(k), k, 16'hA000 + 16'(b * 16'h1000) + 16'(k));
        else n_pass++;
      end
    end
  endtask

  task automatic test_supersede_pending();
    bit ok, all_ok;
    clear_q();
    set_req(0, 25'h000300);
    set_req(2, 25'h002A00);
    fire();
    tick(1);
    set_req(2, 25'h002B00);
    fire();
    serve(1, 1, 16'h3333, ok); all_ok = ok;
    serve(1, 1, 16'h2B2B, ok); all_ok &= ok;
    tick(3);
    n_checks++;
    if (!all_ok || issue_q.size() != 2 || issue_q[0] !== 25'h000300 || issue_q[1] !== 25'h002B00)
      $display("FAIL supersede_pending_issue: got ok=%b n=%0d first=%h second=%h expected 2 reads 000300 002b00", all_ok, issue_q.size(), issue_q[0], issue_q[1]);
    else n_pass++;
    n_checks++;
    if (rdy_port_q.size() != 2 || rdy_port_q[0] != 0 || rdy_port_q[1] != 2 || rdy_data_q[1] !== 16'h2B2B || rdata[2*DW +: DW] !== 16'h2B2B)
      $display("FAIL supersede_pending_rdy: got n=%0d ports=%0d,%0d rdata2=%h expected ports 0,2 rdata2=2b2b", rdy_port_q.size(), rdy_port_q[0], rdy_port_q[1], rdata[2*DW +: DW]);
    else n_pass++;
  endtask

  task automatic test_supersede_flight();
    bit ok, all_ok;
    clear_q();
    set_req(3, 25'h3A0000);
    fire();
    wait_rd(all_ok);
    n_checks++; if (mem_addr !== 25'h3A0000) $display("FAIL flight_first_addr: got %h expected 3a0000", mem_addr); else n_pass++;
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    set_req(3, 25'h3B0000);
    fire();
    mem_dout   = 16'hDEAD;
    mem_dvalid = 1'b1;
    tick(1);
    mem_dvalid = 1'b0;
    n_checks++; if (rdy !== 4'b0000 || rdata[3*DW +: DW] !== 16'hB003) $display("FAIL flight_drop: got rdy=%b rdata3=%h expected rdy=0000 rdata3=b003", rdy, rdata[3*DW +: DW]); else n_pass++;
    serve(1, 1, 16'hB0B0, ok); all_ok &= ok;
    tick(2);
    n_checks++;
    if (!all_ok || issue_q.size() != 2 || issue_q[1] !== 25'h3B0000 || rdy_port_q.size() != 1 || rdy_port_q[0] != 3 || rdy_data_q[0] !== 16'hB0B0)
      $display("FAIL flight_reissue: got ok=%b reads=%0d addr2=%h rdys=%0d port=%0d data=%h expected 2 reads 3b0000, one rdy port 3 b0b0", all_ok, issue_q.size(), issue_q[1], rdy_port_q.size(), rdy_port_q[0], rdy_data_q[0]);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok, all_ok;
    int bad = 0;
    clear_q();
    set_req(1, 25'h011110);
    fire();
    wait_rd(all_ok);
    set_req(0, 25'h000555);
    set_req(2, 25'h000777);
    fire();
    for (int i = 0; i < 20; i++) begin
      if (mem_rd !== 1'b1 || mem_addr !== 25'h011110) bad++;
      tick(1);
    end
    n_checks++; if (bad != 0 || issue_q.size() != 1) $display("FAIL stall_hold: got %0d unstable cycles, %0d reads expected 0 and 1", bad, issue_q.size()); else n_pass++;
    mem_ack = 1'b1; tick(1); mem_ack = 1'b0;
    tick(3);
    mem_dout = 16'h1111; mem_dvalid = 1'b1; tick(1); mem_dvalid = 1'b0;
    serve(0, 1, 16'h2222, ok); all_ok &= ok;
    serve(0, 1, 16'h0A0A, ok); all_ok &= ok;
    tick(2);
    n_checks++;
    if (!all_ok || issue_q.size() != 3 || issue_q[1] !== 25'h000777 || issue_q[2] !== 25'h000555)
      $display("FAIL stall_order_addr: got ok=%b n=%0d %h %h expected 3 reads then 000777 000555", all_ok, issue_q.size(), issue_q[1], issue_q[2]);
    else n_pass++;
    n_checks++;
    if (rdy_port_q.size() != 3 || rdy_port_q[0] != 1 || rdy_port_q[1] != 2 || rdy_port_q[2] != 0 || rdy_data_q[0] !== 16'h1111 || rdy_data_q[2] !== 16'h0A0A)
      $display("FAIL stall_order_rdy: got n=%0d ports %0d,%0d,%0d expected ports 1,2,0", rdy_port_q.size(), rdy_port_q[0], rdy_port_q[1], rdy_port_q[2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    clear_q();
    set_req(0, 25'h000040);
    fire();
    wait_rd(all_ok);
    mem_ack = 1'b1; tick(1); mem_ack = 1'b0;
    tick(1);
    do_reset();
    mem_dout = 16'h5A5A; mem_dvalid = 1'b1; tick(1); mem_dvalid = 1'b0;
    tick(1);
    n_checks++; if (rdy_port_q.size() != 0 || rdy !== '0) $display("FAIL reset_mid_rdy: got %0d pulses rdy=%b expected none", rdy_port_q.size(), rdy); else n_pass++;
    n_checks++; if (rdata !== {PORTS*DW{1'b1}} || mem_rd !== 1'b0) $display("FAIL reset_mid_state: got rdata=%h rd=%b expected all ones rd=0", rdata, mem_rd); else n_pass++;
    set_req(0, 25'h000044);
    fire();
    serve(1, 1, 16'h4444, ok); all_ok &= ok;
    tick(1);
    n_checks++;
    if (!all_ok || issue_q.size() != 1 || issue_q[0] !== 25'h000044 || rdy_port_q.size() != 1 || rdy_port_q[0] != 0 || rdata[DW-1:0] !== 16'h4444)
      $display("FAIL reset_mid_after: got ok=%b reads=%0d addr=%h rdys=%0d rdata0=%h expected 1 read 000044, rdy port 0, 4444", all_ok, issue_q.size(), issue_q[0], rdy_port_q.size(), rdata[DW-1:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_supersede_pending();
    test_supersede_flight();
    test_stall();
    test_reset_mid();
    n_checks++; if (multi_rdy != 0) $display("FAIL onehot_rdy: got %0d multi-bit cycles expected 0", multi_rdy); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
